sar_search: RTL and testbench

//   Successive-approximation searcher: the driving end of a combinational

---
 rtl/sar_pkg.sv | 17 +
 rtl/sar_search.sv | 76 +++++++
 tb/tb_sar_search.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation searcher: state encoding
// and the default search width.
package sar_pkg;

   localparam logic [1:0] SAR_IDLE   = 2'd0;
   localparam logic [1:0] SAR_SEARCH = 2'd1;
   localparam logic [1:0] SAR_DONE   = 2'd2;

   localparam int SAR_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = SAR_IDLE,
      ST_SEARCH = SAR_SEARCH,
      ST_DONE   = SAR_DONE
   } sar_state_t;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation searcher driving the B side of an external A>B
// comparator; recovers A MSB-first in W cycles. Build option: SAR_RESTART_EN.
//
// state  | meaning
// IDLE   | waiting for start; guess/result hold last recovered value
// SEARCH | one bit resolved per cycle, idx counts down from W-1
// DONE   | single-cycle done pulse, result valid; always returns to IDLE
module sar_search
   import sar_pkg::*;
#(
   parameter int W = SAR_W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         cmp_gt,
   output logic [W-1:0] guess,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result
);

   localparam int             IW      = (W > 1) ? $clog2(W) : 1;
   localparam logic [IW-1:0]  IDX_TOP = IW'(W - 1);
   localparam logic [W-1:0]   ONE     = W'(1);

   sar_state_t    state;
   logic [W-1:0]  r;
   logic [IW-1:0] idx;
   logic [W-1:0]  bit_sel;

   assign bit_sel = ONE << idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         r     <= '0;
         idx   <= IDX_TOP;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_SEARCH;
                  r     <= '0;
                  idx   <= IDX_TOP;
               end
            end
            ST_SEARCH: begin
`ifdef SAR_RESTART_EN
               if (start) begin
                  r   <= '0;
                  idx <= IDX_TOP;
               end else
`endif
               begin
                  if (cmp_gt)
                     r <= r | bit_sel;
                  if (idx == '0)
                     state <= ST_DONE;
                  else
                     idx <= idx - IW'(1);
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Trial value: resolved upper bits, current bit 0, all lower bits 1.
   assign guess  = (state == ST_SEARCH) ? (r | (bit_sel - ONE)) : r;
   assign busy   = (state == ST_SEARCH);
   assign done   = (state == ST_DONE);
   assign result = r;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search (W=4) with a behavioural A>B comparator.
module tb_sar_search;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         cmp_gt;
   logic [W-1:0] guess;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic [W-1:0] a_val;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] g [W];
      logic [W-1:0] res;
   } vec_t;

   vec_t tbl [4];

   always #5 clk = ~clk;

   assign cmp_gt = (a_val > guess);

   sar_search #(.W(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .cmp_gt (cmp_gt),
      .guess  (guess),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Step i probes bit b=W-1-i: A's bits above b, zero at b, ones below b.
   function automatic logic [W-1:0] model_guess(input int a, input int step);
      int b;
      int hi;
      b  = W - 1 - step;
      hi = (a >> (b + 1)) << (b + 1);
      return W'(hi | ((1 << b) - 1));
   endfunction

   // Called in IDLE just after an edge; returns one cycle into IDLE after DONE.
   task automatic run_search(input logic [W-1:0] a, input logic [W-1:0] eg [W],
                             input logic [W-1:0] eres);
      a_val = a;
      start = 1'b1;
      for (int i = 0; i < W; i++) begin
         tick();
         start = 1'b0;
         chk($sformatf("busy a=%0d step%0d", a, i), int'(busy), 1);
         chk($sformatf("guess a=%0d step%0d", a, i), int'(guess), int'(eg[i]));
         chk($sformatf("done_low a=%0d step%0d", a, i), int'(done), 0);
      end
      tick();
      chk($sformatf("done a=%0d", a), int'(done), 1);
      chk($sformatf("result a=%0d", a), int'(result), int'(eres));
      tick();
      chk($sformatf("done_clear a=%0d", a), int'(done), 0);
      chk($sformatf("result_hold a=%0d", a), int'(result), int'(eres));
      chk($sformatf("guess_hold a=%0d", a), int'(guess), int'(eres));
   endtask

   initial begin
      logic [W-1:0] eg [W];
      int n;
      int exp_n;

      tbl[0].a = 4'd9;  tbl[0].g = '{4'd7, 4'd11, 4'd9,  4'd8};  tbl[0].res = 4'd9;
      tbl[1].a = 4'd0;  tbl[1].g = '{4'd7, 4'd3,  4'd1,  4'd0};  tbl[1].res = 4'd0;
      tbl[2].a = 4'd15; tbl[2].g = '{4'd7, 4'd11, 4'd13, 4'd14}; tbl[2].res = 4'd15;
      tbl[3].a = 4'd6;  tbl[3].g = '{4'd7, 4'd3,  4'd5,  4'd6};  tbl[3].res = 4'd6;

      reset = 1'b1;
      start = 1'b0;
      a_val = '0;
      tick();
      tick();
      chk("rst guess", int'(guess), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst done", int'(done), 0);
      chk("rst result", int'(result), 0);
      reset = 1'b0;
      tick();
      chk("idle busy", int'(busy), 0);

      // Directed table
      for (int t = 0; t < 4; t++)
         run_search(tbl[t].a, tbl[t].g, tbl[t].res);

      // Randomized values against the arithmetic model
      for (int t = 0; t < 24; t++) begin
         int a;
         a = int'($urandom_range(0, (1 << W) - 1));
         for (int i = 0; i < W; i++)
            eg[i] = model_guess(a, i);
         run_search(W'(a), eg, W'(a));
      end

      // Back-to-back sweep with start held high
      start = 1'b1;
      for (int a = 0; a < (1 << W); a++) begin
         a_val = W'(a);
         exp_n = (a == 0) ? W + 1 : W + 2;
         n = 0;
         do begin
            tick();
            n++;
         end while (!done && n < 12);
         chk($sformatf("sweep cycles a=%0d", a), n, exp_n);
         chk($sformatf("sweep result a=%0d", a), int'(result), a);
      end
      start = 1'b0;
      tick();
      tick();
      chk("sweep idle", int'(busy), 0);

      // Reset in the middle of a search
      a_val = 4'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("mid guess2", int'(guess), 11);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst busy", int'(busy), 0);
      chk("mid_rst guess", int'(guess), 0);
      chk("mid_rst result", int'(result), 0);
      chk("mid_rst done", int'(done), 0);
      tick();
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done || busy) n++;
      end
      chk("post_rst quiet", n, 0);
      for (int i = 0; i < W; i++)
         eg[i] = model_guess(5, i);
      run_search(4'd5, eg, 4'd5);

      // Second start pulse while searching
      a_val = 4'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (!done && n < 12) begin
         tick();
         n++;
      end
`ifdef SAR_RESTART_EN
      chk("restart done latency", n, W + 1);
`else
      chk("ignore start latency", n, W - 1);
`endif
      chk("restart result", int'(result), 9);
      tick();
      chk("restart back idle", int'(done), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
